score_ctrl: RTL and testbench
=============================

Name: score_ctrl

Overview:
- Arbitrates point-award requests from several game sources, such as brick-colour hit detectors and a bonus generator.
- Sequences each award into a synchronous 4-digit BCD score register, one point per clock.
- Tracks the session high score and holds the score at 9999.
- Sits between the collision/game logic and the seven-segment display driver, and replaces the ripple-clocked score chain with a single-clock design.

Parameters:
- NREQ, 4, number of requesters.
- PW, 4, width of each point-value field; maximum award is 2^PW-1 = 15.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr_score  in  1  synchronous new-game clear.
- req  in  NREQ  per-requester award request; level signal.
- pts  in  [NREQ-1:0][PW-1:0]  point value for each requester; must be stable while its req is high.
- ack  out  NREQ  one-cycle grant/acknowledge pulse, one-hot.
- score  out  [3:0][3:0]  BCD score; digit 0 is the least significant.
- hi_score  out  [3:0][3:0]  BCD high score.
- busy  out  1  high while points are being counted.
- sat  out  1  score is held at 9999.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, score=0000, hi_score=0000, ack=0, busy=0, sat=0, rem=0.
  - Round-robin pointer last=NREQ-1, so req[0] has first priority.
- States: IDLE, COUNT.
- IDLE:
  - If clr_score=1: clear score to 0000 and sat=0; issue no grant.
  - Otherwise, eligible requests are req[i]=1 with ack[i]=0.
  - Pick the first eligible i scanning last+1, last+2, … modulo NREQ.
  - On that edge: ack[i]<=1, last<=i, rem<=pts[i].
  - If pts[i]!=0, go to COUNT with busy<=1; otherwise stay in IDLE.
- Requester handshake:
  - The requester holds req and pts until it sees ack.
  - It deasserts req in the cycle following ack.
  - A requester with ack high is never granted in that same cycle.
- COUNT:
  - Each edge: if score!=9999, score<=score+1 with BCD carry (digit 9 -> 0 carries into the next digit). Always rem<=rem-1.
  - When rem==1 on an edge: go to IDLE with busy<=0.
  - An award of P therefore occupies exactly P COUNT edges.
  - The next grant can occur on the edge after COUNT exits.
  - No req is sampled during COUNT; requests wait.
- Saturation:
  - At 9999 increments are dropped and rem still drains.
  - sat goes high on the edge at which score becomes 9999, and stays high until clr_score or reset.
- clr_score in any state:
  - On that edge: score<=0000, sat<=0, rem<=0, state<=IDLE, busy<=0, no ack.
  - An in-flight award is discarded.
  - clr_score has priority over a simultaneous req and over a simultaneous increment.
  - hi_score is retained.
- High score:
  - Registered compare, one cycle behind score: if score > hi_score (BCD, MSD-first lexicographic compare), hi_score<=score.
  - hi_score never decreases except on reset.
- ack is registered and zero in all cycles other than the grant edge.
- An asynchronous reset mid-COUNT aborts immediately to reset values.

Decomposition:
- Package score_pkg holds:
  - typedef bcd_t (logic [3:0]) and bcd4_t (bcd_t [3:0]);
  - state enum {IDLE, COUNT};
  - constant BCD_MAX = 9999 as bcd4_t.
- Sub-module bcd_score_reg: 4-digit synchronous BCD register with inputs inc and clr, outputs q and at_max, saturating, asynchronous active-low rst.
- Arbitration, FSM and high-score compare stay in score_ctrl.

Test Plan:
- Single award: rst release, req[2]=1 with pts[2]=3.
  - ack[2] pulses the next cycle.
  - busy is high for 3 cycles.
  - score goes 0001, 0002, 0003.
  - hi_score=0003 one cycle later.
- Round robin: req[0] and req[1] held together, pts=1 each, each requester re-raising req after its ack.
  - Grants alternate 0,1,0,1.
  - Never two consecutive grants to the same requester while the other is pending.
- BCD carry: preload to 0098 via awards, then award 5.
  - score steps 0099, 0100, 0101, 0102, 0103.
- Saturation: reach 9997, then award 15.
  - score stops at 9999 and sat=1.
  - busy is still high for 15 cycles.
  - hi_score=9999.
- clr_score mid-COUNT: during an award of 10 after 4 increments, with score=0004.
  - Next cycle score=0000, busy=0, IDLE.
  - hi_score remains 0004.
  - A concurrent req is not acked in the clr cycle.
- Zero award, then reset: pts=0 request.
  - ack pulses, busy stays 0, score unchanged.
  - Then assert rst asynchronously mid-COUNT: all outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score controller.
package score_pkg;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [3:0] bcd4_t;

  typedef enum logic {IDLE, COUNT} state_t;

  localparam bcd4_t BCD_MAX = 16'h9999;

  // Add one to a 4-digit BCD value with decimal carry (9999 wraps to 0000).
  function automatic bcd4_t bcd_inc(input bcd4_t v);
    bcd4_t r;
    logic  c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (v[d] == 4'd9) begin
          r[d] = 4'd0;
        end else begin
          r[d] = v[d] + 4'd1;
          c    = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_reg.sv
// Four-digit synchronous BCD counter that saturates at 9999.
module bcd_score_reg
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0][3:0] q,
  output logic       at_max
);

  bcd4_t q_q, q_d;

  // Clear wins over increment; increments at the maximum are dropped.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != BCD_MAX)) begin
      q_d = bcd_inc(q_q);
    end
  end

  // Score register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == BCD_MAX);

endmodule

// File: rtl/score_ctrl.sv
// Round-robin point-award arbiter feeding a saturating BCD score with high-score tracking.
module score_ctrl
  import score_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_score,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0][PW-1:0]   pts,
  output logic [NREQ-1:0]           ack,
  output logic [3:0][3:0]           score,
  output logic [3:0][3:0]           hi_score,
  output logic                      busy,
  output logic                      sat
);

  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [LW-1:0]   last_q, last_d;
  logic [PW-1:0]   rem_q, rem_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  bcd4_t           hi_q;
  bcd4_t           score_w;
  logic            inc;
  logic            at_max;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [LW-1:0]   sel;
  logic [LW-1:0]   cand;

  // A requester whose ack is high this cycle is not eligible again yet.
  assign elig = req & ~ack_q;

  // Round-robin pick: first eligible requester after the last winner.
  always_comb begin
    found = 1'b0;
    sel   = last_q;
    cand  = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = LW'((int'(last_q) + k) % int'(NREQ));
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state logic: grant in IDLE, drain one point per edge in COUNT.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rem_d   = rem_q;
    ack_d   = '0;
    busy_d  = busy_q;
    inc     = 1'b0;
    if (clr_score) begin
      state_d = IDLE;
      rem_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            ack_d[sel] = 1'b1;
            last_d     = sel;
            rem_d      = pts[sel];
            if (pts[sel] != '0) begin
              state_d = COUNT;
              busy_d  = 1'b1;
            end
          end
        end
        COUNT: begin
          inc   = 1'b1;
          rem_d = rem_q - PW'(1);
          if (rem_q == PW'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= LW'(NREQ - 1);
      rem_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  bcd_score_reg u_score (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_score),
    .inc    (inc),
    .q      (score_w),
    .at_max (at_max)
  );

  // High score follows score one cycle late; a packed BCD compare is already MSD-first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
    end else if (score_w > hi_q) begin
      hi_q <= score_w;
    end
  end

  assign ack      = ack_q;
  assign score    = score_w;
  assign hi_score = hi_q;
  assign busy     = busy_q;
  assign sat      = at_max;

endmodule

// File: tb/tb_score_ctrl.sv
// Self-checking bench for score_ctrl using a decimal-integer reference model.
module tb_score_ctrl;

  localparam int NREQ = 4;
  localparam int PW   = 4;

  logic                    clk;
  logic                    rst;
  logic                    clr_score;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][PW-1:0] pts;
  logic [NREQ-1:0]         ack;
  logic [3:0][3:0]         score;
  logic [3:0][3:0]         hi_score;
  logic                    busy;
  logic                    sat;

  int n_checks = 0;
  int n_fail   = 0;
  int s_m      = 0;  // model score, plain decimal
  int hi_m     = 0;  // model high score, plain decimal

  score_ctrl #(.NREQ(NREQ), .PW(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_score (clr_score),
    .req       (req),
    .pts       (pts),
    .ack       (ack),
    .score     (score),
    .hi_score  (hi_score),
    .busy      (busy),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Advance one clock and compare against the model. High score lags score by one edge.
  task automatic step(input bit inc_e, input bit busy_e, input logic [NREQ-1:0] ack_e,
                      input bit clr_e);
    @(negedge clk);
    if (s_m > hi_m) hi_m = s_m;
    if (clr_e) s_m = 0;
    else if (inc_e && s_m < 9999) s_m++;
    check("score", 32'(score), 32'(to_bcd(s_m)));
    check("hi_score", 32'(hi_score), 32'(to_bcd(hi_m)));
    check("busy", 32'(busy), 32'(busy_e));
    check("sat", 32'(sat), 32'(s_m == 9999));
    check("ack", 32'(ack), 32'(ack_e));
  endtask

  // One full award: request, grant next edge, then p counting edges.
  task automatic award(input int i, input int p);
    req[i] = 1'b1;
    pts[i] = PW'(p);
    step(1'b0, p != 0, NREQ'(1) << i, 1'b0);
    req[i] = 1'b0;
    for (int k = 1; k <= p; k++) step(1'b1, k < p, '0, 1'b0);
    if (p == 0) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic clear();
    clr_score = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1);
    clr_score = 1'b0;
  endtask

  // Random awards that land exactly on target.
  task automatic preload(input int target, input int pmin);
    int p;
    while (s_m < target) begin
      p = int'($urandom_range(pmin, 15));
      if (p > target - s_m) p = target - s_m;
      award(int'($urandom_range(0, NREQ - 1)), p);
    end
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic async_reset();
    req = '0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_score", 32'(score), 32'h0);
    check("rst_hi", 32'(hi_score), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sat", 32'(sat), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    @(negedge clk);
    rst  = 1'b1;
    s_m  = 0;
    hi_m = 0;
  endtask

  initial begin
    logic [NREQ-1:0] a;
    int grants[$];
    bit raise [2];

    rst = 1'b0; clr_score = 1'b0; req = '0; pts = '0;
    #1;
    check("reset_score", 32'(score), 32'h0);
    check("reset_hi", 32'(hi_score), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_sat", 32'(sat), 32'h0);
    check("reset_ack", 32'(ack), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single award of 3 from requester 2.
    award(2, 3);
    step(1'b0, 1'b0, '0, 1'b0);
    check("single_hi", 32'(hi_score), 32'h0003);

    // Clear mid-count with a competing request in the clear cycle.
    clear();
    req[1] = 1'b1; pts[1] = 4'd10;
    step(1'b0, 1'b1, 4'b0010, 1'b0);
    req[1] = 1'b0;
    repeat (4) step(1'b1, 1'b1, '0, 1'b0);
    check("pre_clr_score", 32'(score), 32'h0004);
    clr_score = 1'b1; req[3] = 1'b1; pts[3] = 4'd2;
    step(1'b0, 1'b0, '0, 1'b1);
    clr_score = 1'b0; req[3] = 1'b0;
    step(1'b0, 1'b0, '0, 1'b0);
    check("clr_hi", 32'(hi_score), 32'h0004);

    // Round robin from reset: requesters 0 and 1 alternate.
    async_reset();
    pts[0] = 4'd1; pts[1] = 4'd1;
    req[0] = 1'b1; req[1] = 1'b1;
    raise[0] = 1'b0; raise[1] = 1'b0;
    for (int c = 0; c < 24 && grants.size() < 4; c++) begin
      @(negedge clk);
      a = ack;
      if (a != '0) begin
        check("rr_onehot", 32'($countones(a)), 32'd1);
        for (int j = 0; j < 2; j++) begin
          if (a[j]) begin
            grants.push_back(j);
            req[j]   = 1'b0;
            raise[j] = 1'b1;
          end
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          if (raise[j]) begin
            req[j]   = 1'b1;
            raise[j] = 1'b0;
          end
        end
      end
    end
    check("rr_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < grants.size(); k++) check("rr_order", 32'(grants[k]), 32'(k % 2));
    async_reset();

    // BCD carry across two digits.
    preload(98, 1);
    award(0, 5);
    check("carry", 32'(score), 32'h0103);

    // Random awards, zero values included.
    for (int n = 0; n < 30; n++)
      award(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 15)));

    // Saturation.
    preload(9997, 8);
    award(3, 15);
    step(1'b0, 1'b0, '0, 1'b0);
    check("sat_score", 32'(score), 32'h9999);
    check("sat_flag", 32'(sat), 32'h1);
    check("sat_hi", 32'(hi_score), 32'h9999);

    // Zero award, then asynchronous reset in the middle of a count.
    award(1, 0);
    check("zero_score", 32'(score), 32'h9999);
    req[2] = 1'b1; pts[2] = 4'd9;
    step(1'b0, 1'b1, 4'b0100, 1'b0);
    req[2] = 1'b0;
    repeat (2) step(1'b1, 1'b1, '0, 1'b0);
    async_reset();
    step(1'b0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
